mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit.
- Drives the 2-bit select lines (alusrcb, pcsrc) and the enables of the multicycle datapath's 3-input and 4-input muxes, registers and memory.
- Registered Moore FSM plus a combinational ALU decoder.
- Sits beside the datapath in the processor top level; consumes op/funct from the instruction register and zero from the ALU.

Parameters:
- none; opcode, funct and state encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- op  input  6  instr[31:26] from instruction register.
- funct  input  6  instr[5:0] from instruction register.
- zero  input  1  ALU zero flag.
- iord  output  1  memory address mux select (0 = PC, 1 = ALUOut).
- memwrite  output  1  data memory write enable.
- irwrite  output  1  instruction register load enable.
- regdst  output  1  write-register mux select (0 = rt, 1 = rd).
- memtoreg  output  1  write-data mux select (0 = ALUOut, 1 = Data).
- regwrite  output  1  register file write enable.
- alusrca  output  1  SrcA mux select (0 = PC, 1 = A).
- alusrcb  output  2  SrcB mux select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  output  2  PC-next mux select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC register enable.
- alucontrol  output  3  ALU operation.
- state  output  4  current FSM state, for debug and bench use.

Behaviour:
- reset = 0 (asynchronous): state = FETCH immediately, with no clock edge required.
- During reset, outputs show FETCH decode: irwrite = 1, pcen = 1, alusrcb = 01; all other outputs 0; alucontrol = 010.
- Reset asserted mid-instruction: abandon the instruction and return to FETCH; no partial writes after the asserting edge.
- All control outputs except pcen and alucontrol are pure functions of state (Moore); no output depends combinationally on op.
- pcen = pcwrite | (branch & zero), combinational. pcwrite and branch are internal Moore signals.
- Transitions occur on the rising clk edge:
  - FETCH -> DECODE always.
  - DECODE: op 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> RTYPEEX; 000100 (beq) -> BEQEX; 001000 (addi) -> ADDIEX; 000010 (j) -> JEX.
  - DECODE, any other op -> FETCH. The instruction is silently skipped; PC is already advanced.
  - MEMADR: lw -> MEMRD; sw -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - RTYPEEX -> RTYPEWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BEQEX -> FETCH.
  - JEX -> FETCH.
  - Unused state encodings -> FETCH.
- Outputs by state. Unlisted outputs are 0.
  - FETCH: alusrcb = 01, aluop = 00, irwrite, pcwrite.
  - DECODE: alusrcb = 11, aluop = 00.
  - MEMADR and ADDIEX: alusrca, alusrcb = 10, aluop = 00.
  - MEMRD: iord.
  - MEMWR: iord, memwrite.
  - MEMWB: memtoreg, regwrite.
  - RTYPEEX: alusrca, aluop = 10.
  - RTYPEWB: regdst, regwrite.
  - ADDIWB: regwrite.
  - BEQEX: alusrca, aluop = 01, pcsrc = 01, branch.
  - JEX: pcsrc = 10, pcwrite.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2.
- ALU decode from aluop:
  - 00 -> 010 (add).
  - 01 -> 110 (sub).
  - 11 -> 010.
  - 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 000 (never X).

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum statetype_t (4-bit logic): FETCH = 0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
  - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J.
  - funct localparams.
  - select constants SRCB_B/4/IMM/IMMSH and PCSRC_ALU/ALUOUT/JUMP.
- Sub-module aludec (aluop, funct -> alucontrol), purely combinational.
- The FSM state register and output decode stay in mips_multicycle_ctrl.

Test Plan:
- Hold reset = 0 for 3 cycles, release -> state = FETCH; irwrite = 1, pcen = 1, alusrcb = 01; memwrite = 0, regwrite = 0.
- op = 100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - MEMADR: alusrcb = 10.
  - MEMRD: iord = 1.
  - MEMWB: regwrite = 1, memtoreg = 1.
  - 5 cycles total.
- op = 000000, funct = 101010 -> in RTYPEEX alucontrol = 111, alusrca = 1; in RTYPEWB regdst = 1, regwrite = 1.
  - Repeat with funct = 100101 -> alucontrol = 001.
- op = 000100 in BEQEX:
  - zero = 1 -> pcen = 1, pcsrc = 01, alucontrol = 110.
  - zero = 0 -> pcen = 0.
  - Back in FETCH next cycle.
- op = 000010 -> JEX with pcsrc = 10, pcen = 1.
- op = 111111 -> DECODE then FETCH; no regwrite or memwrite pulse.
- Reset asserted asynchronously mid-MEMWR (between edges) -> memwrite drops to 0 immediately; state = FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// aludec: maps aluop and funct to the 3-bit ALU operation
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  logic [2:0] funct_ctl;
  // funct field decode; unknown functs fall back to AND so the output is never X
  always_comb begin
    funct_ctl = ALU_AND;
    case (funct)
      F_ADD:   funct_ctl = ALU_ADD;
      F_SUB:   funct_ctl = ALU_SUB;
      F_AND:   funct_ctl = ALU_AND;
      F_OR:    funct_ctl = ALU_OR;
      F_SLT:   funct_ctl = ALU_SLT;
      default: funct_ctl = ALU_AND;
    endcase
  end
  // aluop 01 subtracts for beq, 10 defers to funct, 00 and 11 add
  always_comb begin
    alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                 aluop == ALUOP_FUNCT ? funct_ctl : ALU_ADD;
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM and ALU decode for the multicycle MIPS datapath
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);
  statetype_t state_q, state_d;
  logic       pcwrite, branch;
  logic [1:0] aluop;

  // state register; active-low reset forces FETCH without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // next-state logic; unsupported opcodes and stray encodings return to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      MEMADR:  state_d = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode, every output defaults to inactive
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PCSRC_ALU;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        alusrcb = SRCB_4;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = SRCB_IMMSH;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD:   iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB:  regwrite = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and random instruction walks against a trace model
module tb_mips_multicycle_ctrl;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_RTYPEEX = 6, S_RTYPEWB = 7, S_BEQEX = 8,
                 S_ADDIEX = 9, S_ADDIWB = 10, S_JEX = 11;

  logic       clk = 1'b0, reset = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  int         tests = 0, fails = 0;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol}
  function automatic logic [14:0] exp_ctl(input int s, input logic [5:0] f, input logic z);
    logic [6:0] flags = '0;
    logic [1:0] srcb = 2'b00, psrc = 2'b00;
    logic       en = 1'b0;
    logic [2:0] alu = 3'b010;
    case (s)
      S_FETCH:   begin flags = 7'b0010000; srcb = 2'b01; en = 1'b1; end
      S_DECODE:  srcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin flags = 7'b0000001; srcb = 2'b10; end
      S_MEMRD:   flags = 7'b1000000;
      S_MEMWR:   flags = 7'b1100000;
      S_MEMWB:   flags = 7'b0000110;
      S_RTYPEEX: begin flags = 7'b0000001; alu = alu_for_funct(f); end
      S_RTYPEWB: flags = 7'b0001010;
      S_ADDIWB:  flags = 7'b0000010;
      S_BEQEX:   begin flags = 7'b0000001; psrc = 2'b01; en = z; alu = 3'b110; end
      S_JEX:     begin psrc = 2'b10; en = 1'b1; end
      default:   ;
    endcase
    return {flags, srcb, psrc, en, alu};
  endfunction

  function automatic logic is_supported(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // one instruction from FETCH back to FETCH; zmode 0/1 forces zero, 2 randomizes it per cycle
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f, input int zmode);
    int seq[$];
    seq = {S_FETCH, S_DECODE};
    case (o)
      6'b100011: seq = {seq, S_MEMADR, S_MEMRD, S_MEMWB};
      6'b101011: seq = {seq, S_MEMADR, S_MEMWR};
      6'b000000: seq = {seq, S_RTYPEEX, S_RTYPEWB};
      6'b001000: seq = {seq, S_ADDIEX, S_ADDIWB};
      6'b000100: seq.push_back(S_BEQEX);
      6'b000010: seq.push_back(S_JEX);
      default:   ;
    endcase
    op = o;
    funct = f;
    foreach (seq[i]) begin
      zero = zmode == 2 ? 1'($urandom) : 1'(zmode);
      #2;
      check($sformatf("%s.state%0d", tag, i), 32'(state), 32'(seq[i]));
      check($sformatf("%s.ctl%0d", tag, i),
            32'({iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol}),
            32'(exp_ctl(seq[i], f, zero)));
      @(posedge clk);
      #1;
    end
    #2;
    check({tag, ".back_to_fetch"}, 32'(state), S_FETCH);
  endtask

  initial begin
    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
    logic [5:0] o, f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.state", 32'(state), S_FETCH);
    check("rst.irwrite", 32'(irwrite), 1);
    check("rst.pcen", 32'(pcen), 1);
    check("rst.alusrcb", 32'(alusrcb), 1);
    check("rst.memwrite", 32'(memwrite), 0);
    check("rst.regwrite", 32'(regwrite), 0);
    check("rst.alucontrol", 32'(alucontrol), 3'b010);
    reset = 1'b1;
    #1;
    run_instr("lw", 6'b100011, 6'b000000, 2);
    run_instr("slt", 6'b000000, 6'b101010, 2);
    run_instr("or", 6'b000000, 6'b100101, 2);
    run_instr("beq_taken", 6'b000100, 6'b000000, 1);
    run_instr("beq_not", 6'b000100, 6'b000000, 0);
    run_instr("j", 6'b000010, 6'b000000, 2);
    run_instr("bad_op", 6'b111111, 6'b000000, 2);
    run_instr("addi", 6'b001000, 6'b000000, 2);
    run_instr("sw", 6'b101011, 6'b000000, 2);
    for (int n = 0; n < 40; n++) begin
      o = $urandom_range(0, 3) == 0 ? 6'($urandom) : ops[$urandom_range(0, 5)];
      f = $urandom_range(0, 4) == 0 ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(is_supported(o) ? "rnd" : "rnd_bad", o, f, 2);
    end
    op = 6'b101011;
    repeat (3) @(posedge clk);
    #2;
    check("mid.in_memwr", 32'(state), S_MEMWR);
    check("mid.memwrite_hi", 32'(memwrite), 1);
    reset = 1'b0;
    #1;
    check("mid.memwrite_drop", 32'(memwrite), 0);
    check("mid.state", 32'(state), S_FETCH);
    check("mid.irwrite", 32'(irwrite), 1);
    @(posedge clk);
    #1;
    check("mid.hold_fetch", 32'(state), S_FETCH);
    @(negedge clk);
    reset = 1'b1;
    #1;
    run_instr("after_rst_lw", 6'b100011, 6'b100000, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
